// File: rtl/imm_ext_reg.sv
// Immediate-extension register: sign/zero extends D onto Q, or
// (with IMM_EXT_ROT_EN) builds the rotated immediate imm8 ROR 2*rot4.
// Ports: CLK, CLR (async low), EN (low = load), MODE, D -> Q, BUSY, VALID.
// Optional macro: IMM_EXT_ROT_EN enables the iterative rotate mode.
module imm_ext_reg #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [IN_W-1:0]  D,
  output logic [OUT_W-1:0] Q,
  output logic             BUSY,
  output logic             VALID
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  assign sext = {{(OUT_W-IN_W){D[IN_W-1]}}, D};
  assign zext = {{(OUT_W-IN_W){1'b0}}, D};

`ifdef IMM_EXT_ROT_EN

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ROT  = 1'b1;

  logic [0:0]       state;
  logic [3:0]       cnt;
  logic [OUT_W-1:0] imm8;
  logic [OUT_W-1:0] q_ror2;
  logic [3:0]       rot4;

  assign rot4   = D[11:8];
  assign imm8   = {{(OUT_W-8){1'b0}}, D[7:0]};
  assign q_ror2 = {Q[1:0], Q[OUT_W-1:2]};
  assign BUSY   = (state == ROT);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= IDLE;
      cnt   <= 4'd0;
      Q     <= '0;
      VALID <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (!EN) begin
            case (MODE)
              2'b01: begin
                Q     <= zext;
                VALID <= 1'b1;
              end
              2'b10: begin
                Q   <= imm8;
                cnt <= rot4;
                // rot4 = 0 needs no rotation, so it completes at once
                if (rot4 == 4'd0) begin
                  VALID <= 1'b1;
                end else begin
                  state <= ROT;
                end
              end
              default: begin
                Q     <= sext;
                VALID <= 1'b1;
              end
            endcase
          end
        end
        ROT: begin
          // one 2-bit rotate step per edge; EN/MODE/D ignored here
          Q   <= q_ror2;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            VALID <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  logic zsel;

  // without the rotate logic, MODE 10 falls back to zero-extend
  assign zsel = (MODE == 2'b01) || (MODE == 2'b10);
  assign BUSY = 1'b0;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      Q     <= '0;
      VALID <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (!EN) begin
        Q     <= zsel ? zext : sext;
        VALID <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_imm_ext_reg.sv
// Self-checking bench for imm_ext_reg.
// Table-driven single-cycle loads plus hand sequences for rotate/reset.
module tb_imm_ext_reg;

  logic        CLK;
  logic        CLR;
  logic        EN;
  logic [1:0]  MODE;
  logic [11:0] D;
  logic [31:0] Q;
  logic        BUSY;
  logic        VALID;

  int n_chk;
  int n_fail;

  imm_ext_reg #(.IN_W(12), .OUT_W(32)) dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .EN   (EN),
    .MODE (MODE),
    .D    (D),
    .Q    (Q),
    .BUSY (BUSY),
    .VALID(VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] d;
    logic [31:0] q;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

`ifdef IMM_EXT_ROT_EN
  task automatic rot_seq(input logic [11:0] d, input logic [31:0] exp,
                         input int r);
    EN   = 1'b0;
    MODE = 2'b10;
    D    = d;
    step();
    EN = 1'b1;
    for (int i = 0; i < r; i++) begin
      chk("rot_busy", {31'd0, BUSY}, 32'd1);
      chk("rot_novalid", {31'd0, VALID}, 32'd0);
      step();
    end
    chk("rot_done_busy", {31'd0, BUSY}, 32'd0);
    chk("rot_done_valid", {31'd0, VALID}, 32'd1);
    chk("rot_q", Q, exp);
    step();
    chk("rot_valid_pulse", {31'd0, VALID}, 32'd0);
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{2'b00, 12'h800, 32'hFFFFF800};
    vecs[1] = '{2'b01, 12'h800, 32'h00000800};
    vecs[2] = '{2'b11, 12'h7FF, 32'h000007FF};
    vecs[3] = '{2'b11, 12'h801, 32'hFFFFF801};
    vecs[4] = '{2'b00, 12'h123, 32'h00000123};
    vecs[5] = '{2'b01, 12'hFFF, 32'h00000FFF};
    vecs[6] = '{2'b10, 12'h0AB, 32'h000000AB};

    // reset with a pending load request
    CLR  = 1'b0;
    EN   = 1'b0;
    MODE = 2'b00;
    D    = 12'hFFF;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q", Q, 32'h0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    CLR = 1'b1;
    EN  = 1'b1;
    step();
    chk("rst_rel_q", Q, 32'h0);
    chk("rst_rel_valid", {31'd0, VALID}, 32'd0);

    // back-to-back single-cycle loads
    for (int i = 0; i < 7; i++) begin
      EN   = 1'b0;
      MODE = vecs[i].mode;
      D    = vecs[i].d;
      step();
      chk($sformatf("vec%0d_q", i), Q, vecs[i].q);
      chk($sformatf("vec%0d_valid", i), {31'd0, VALID}, 32'd1);
      chk($sformatf("vec%0d_busy", i), {31'd0, BUSY}, 32'd0);
    end

    // EN high: hold
    EN   = 1'b1;
    MODE = 2'b00;
    D    = 12'h555;
    step();
    chk("hold_q", Q, 32'h000000AB);
    chk("hold_valid", {31'd0, VALID}, 32'd0);
    step();
    chk("hold_q2", Q, 32'h000000AB);

`ifdef IMM_EXT_ROT_EN
    rot_seq(12'h4FF, 32'hFF000000, 4);
    rot_seq(12'hF03, 32'h0000000C, 15);

    // load request during rotation is dropped
    EN   = 1'b0;
    MODE = 2'b10;
    D    = 12'h4FF;
    step();
    MODE = 2'b00;
    D    = 12'h001;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) EN = 1'b1;
      chk("ign_busy", {31'd0, BUSY}, 32'd1);
      step();
    end
    chk("ign_q", Q, 32'hFF000000);
    chk("ign_valid", {31'd0, VALID}, 32'd1);
    step();
    chk("ign_q_hold", Q, 32'hFF000000);
    chk("ign_valid_off", {31'd0, VALID}, 32'd0);

    // reset mid-rotate aborts immediately
    EN   = 1'b0;
    MODE = 2'b10;
    D    = 12'h8FF;
    step();
    EN = 1'b1;
    repeat (3) step();
    chk("abort_pre_busy", {31'd0, BUSY}, 32'd1);
    #2;
    CLR = 1'b0;
    #1;
    chk("abort_q", Q, 32'h0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_valid", {31'd0, VALID}, 32'd0);
    step();
    CLR = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort_no_valid", {31'd0, VALID}, 32'd0);
      chk("abort_q_hold", Q, 32'h0);
    end
`else
    // MODE 10 degrades to zero-extend
    EN   = 1'b0;
    MODE = 2'b10;
    D    = 12'h4FF;
    step();
    EN = 1'b1;
    chk("norot_q", Q, 32'h000004FF);
    chk("norot_valid", {31'd0, VALID}, 32'd1);
    chk("norot_busy", {31'd0, BUSY}, 32'd0);
    step();
    chk("norot_busy2", {31'd0, BUSY}, 32'd0);
    chk("norot_valid_off", {31'd0, VALID}, 32'd0);

    // async reset clears Q away from the clock edge
    #2;
    CLR = 1'b0;
    #1;
    chk("async_rst_q", Q, 32'h0);
    step();
    CLR = 1'b1;
    step();
    chk("async_rst_hold", Q, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
